// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, controller states and flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLT  = 4'b0011,
    OP_ANDN = 4'b0100,
    OP_ORN  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLTS = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_MUL  = 4'b1011
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/seq_alu_if.sv
// Valid/ready operand and result channels between register-read and writeback.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alucontrol;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, alucontrol, out_ready,
    input  in_ready, out_valid, result, zero, neg, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, alucontrol, out_ready,
    output in_ready, out_valid, result, zero, neg, carry, overflow
  );
endinterface

// File: rtl/alu_comb.sv
// Combinational result and flags for every single-cycle opcode (everything except MUL).
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o
);
  localparam int SHW = $clog2(WIDTH);

  logic             is_slt;
  logic             invert;
  logic [WIDTH-1:0] condinvb;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic             arith;
  logic [SHW-1:0]   shamt;

  // Both SLT encodings compare through a subtract, even the one with bit 2 clear.
  assign is_slt   = !op_i[3] && (op_i[1:0] == 2'b11);
  assign invert   = !op_i[3] && (op_i[2] || is_slt);
  assign condinvb = invert ? ~b_i : b_i;
  assign sum      = {1'b0, a_i} + {1'b0, condinvb} + {{WIDTH{1'b0}}, invert};
  assign ovf      = (a_i[WIDTH-1] == condinvb[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
  assign shamt    = b_i[SHW-1:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    result_o = '0;
    arith    = 1'b0;
    case (op_i)
      OP_AND, OP_ANDN: result_o = a_i & condinvb;
      OP_OR,  OP_ORN:  result_o = a_i | condinvb;
      OP_ADD, OP_SUB: begin
        result_o = sum[WIDTH-1:0];
        arith    = 1'b1;
      end
      OP_SLT, OP_SLTS: begin
        result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
        arith    = 1'b1;
      end
      OP_SLL:  result_o = a_i << shamt;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = $signed(a_i) >>> shamt;
      default: result_o = '0;
    endcase
  end

  assign flags_o.zero     = (result_o == '0);
  assign flags_o.neg      = result_o[WIDTH-1];
  assign flags_o.carry    = arith & sum[WIDTH];
  assign flags_o.overflow = arith & ovf;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake and an iterative shift-add multiplier.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      reset_n,
  seq_alu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;

  alu_op_e          op;
  logic [WIDTH-1:0] comb_result;
  alu_flags_t       comb_flags;
  logic             in_ready;
  logic             accept;
  logic             take;
  logic [WIDTH-1:0] acc_next;

  assign op = alu_op_e'(bus.alucontrol);

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i      (bus.a),
    .b_i      (bus.b),
    .op_i     (op),
    .result_o (comb_result),
    .flags_o  (comb_flags)
  );

  assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign take     = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    acc_next    = acc_q + (mplier_q[0] ? mcand_q : '0);

    // A drain clears out_valid; a result loading on the same edge overrides it below.
    if (take) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d  = MUL;
            mcand_d  = bus.a;
            mplier_d = bus.b;
            acc_d    = '0;
            cnt_d    = (SHW+1)'(WIDTH);
          end else begin
            result_d    = comb_result;
            flags_d     = comb_flags;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == (SHW+1)'(1)) begin
          state_d          = IDLE;
          result_d         = acc_next;
          flags_d.zero     = (acc_next == '0);
          flags_d.neg      = acc_next[WIDTH-1];
          flags_d.carry    = 1'b0;
          flags_d.overflow = 1'b0;
          out_valid_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = flags_q.zero;
  assign bus.neg       = flags_q.neg;
  assign bus.carry     = flags_q.carry;
  assign bus.overflow  = flags_q.overflow;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: the driver queues expected responses, a monitor checks each drained result.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;  // zero, neg, carry, overflow
  } resp_t;

  typedef struct {
    string name;
    resp_t r;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic resp_t mk(input logic [WIDTH-1:0] r, input logic [3:0] f);
    resp_t x;
    x.result = r;
    x.flags  = f;
    return x;
  endfunction

  // Monitor: a transfer happens on the next rising edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got result 0x%0h, expected no output", bus.result);
      end else begin
        exp_t  e;
        resp_t act;
        e = exp_q.pop_front();
        act.result = bus.result;
        act.flags  = {bus.zero, bus.neg, bus.carry, bus.overflow};
        check(e.name, 32'(act), 32'(e.r));
      end
    end
  end

  task automatic drive(input alu_op_e op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.in_valid   = 1'b1;
    bus.alucontrol = op;
    bus.a          = a;
    bus.b          = b;
  endtask

  // Waits (bounded) for in_ready, queues the expected response, returns #1 after the accepting edge.
  task automatic wait_accept(input string name, input resp_t exp);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s_accept: in_ready stayed 0, expected 1 within 50 cycles", name);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back('{name: name, r: exp});
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string name, input alu_op_e op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input resp_t exp);
    drive(op, a, b);
    wait_accept(name, exp);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic mul_run(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input resp_t exp);
    issue(name, OP_MUL, a, b, exp);
    idle();
    check({name, "_busy0"}, 32'(bus.in_ready), 32'd0);
    for (int i = 1; i <= WIDTH; i++) begin
      @(posedge clk);
      #1;
      if (i < WIDTH) begin
        check($sformatf("%s_wait%0d_valid", name, i), 32'(bus.out_valid), 32'd0);
        check($sformatf("%s_wait%0d_ready", name, i), 32'(bus.in_ready), 32'd0);
      end else begin
        check({name, "_latency"}, 32'(bus.out_valid), 32'd1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.alucontrol = 4'b0000;
    bus.out_ready  = 1'b1;
    reset_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'h00);
    check("rst_flags", 32'({bus.zero, bus.neg, bus.carry, bus.overflow}), 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Arithmetic flags, then a back-to-back stream of single-cycle ops.
    issue("add_7f_01", OP_ADD, 8'h7F, 8'h01, mk(8'h80, 4'b0101));
    check("add_latency", 32'(bus.out_valid), 32'd1);
    issue("sub_05_05",  OP_SUB,  8'h05, 8'h05, mk(8'h00, 4'b1010));
    issue("slt_80_01",  OP_SLT,  8'h80, 8'h01, mk(8'h01, 4'b0011));
    issue("sra_90_02",  OP_SRA,  8'h90, 8'h02, mk(8'hE4, 4'b0100));
    issue("srl_90_02",  OP_SRL,  8'h90, 8'h02, mk(8'h24, 4'b0000));
    issue("sll_81_09",  OP_SLL,  8'h81, 8'h09, mk(8'h02, 4'b0000));
    issue("slts_01_80", OP_SLTS, 8'h01, 8'h80, mk(8'h00, 4'b1001));
    issue("add_ff_01",  OP_ADD,  8'hFF, 8'h01, mk(8'h00, 4'b1010));
    issue("and_f0_3c",  OP_AND,  8'hF0, 8'h3C, mk(8'h30, 4'b0000));
    issue("andn_f0_3c", OP_ANDN, 8'hF0, 8'h3C, mk(8'hC0, 4'b0100));
    issue("orn_00_ff",  OP_ORN,  8'h00, 8'hFF, mk(8'h00, 4'b1000));
    drive(OP_AND, 8'hFF, 8'hFF);
    bus.alucontrol = 4'b1100;
    wait_accept("rsvd_1100", mk(8'h00, 4'b1000));
    idle();
    @(posedge clk);
    #1;

    mul_run("mul_0d_0b", 8'h0D, 8'h0B, mk(8'h8F, 4'b0100));
    mul_run("mul_ff_ff", 8'hFF, 8'hFF, mk(8'h01, 4'b0000));

    // Backpressure: result must hold, then drain and accept land on one edge.
    bus.out_ready = 1'b0;
    issue("bp_add_03_04", OP_ADD, 8'h03, 8'h04, mk(8'h07, 4'b0000));
    drive(OP_OR, 8'hF0, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_result", i), 32'(bus.result), 32'h07);
      check($sformatf("bp_hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_hold%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    wait_accept("bp_or_f0_0f", mk(8'hFF, 4'b0100));
    idle();
    check("bp_no_gap_valid", 32'(bus.out_valid), 32'd1);
    check("bp_no_gap_result", 32'(bus.result), 32'hFF);
    @(posedge clk);
    #1;

    // Reset while a result is pending.
    bus.out_ready = 1'b0;
    issue("rst_pending_add", OP_ADD, 8'h7F, 8'h01, mk(8'h80, 4'b0101));
    idle();
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst2_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst2_result", 32'(bus.result), 32'h00);
    check("rst2_flags", 32'({bus.zero, bus.neg, bus.carry, bus.overflow}), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    check("rst2_in_ready", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a multiply: the product must never appear.
    issue("mul_abort", OP_MUL, 8'h0D, 8'h0B, mk(8'h8F, 4'b0100));
    idle();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("mul_abort_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("mul_abort_quiet%0d", i), 32'(bus.out_valid), 32'd0);
    end
    issue("post_abort_add", OP_ADD, 8'h01, 8'h01, mk(8'h02, 4'b0000));
    idle();
    check("post_abort_latency", 32'(bus.out_valid), 32'd1);

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
